// File: rtl/filt_sample_tx_if.sv
// Sample link bus: filter samples in, serial line and FIFO status out.
interface filt_sample_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] y_in;
    logic              y_valid;
    logic              tx;
    logic              busy;
    logic              fifo_full;
    logic              fifo_empty;
    logic              overflow;

    modport master (
        output y_in, y_valid,
        input  tx, busy, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  y_in, y_valid,
        output tx, busy, fifo_full, fifo_empty, overflow
    );
endinterface

// File: rtl/filt_sample_tx.sv
// Filter sample transmitter: buffers samples in a FIFO and sends them
// as 8N1-style frames, LSB first, on a single idle-high line.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | line high, waiting for a buffered sample
// START | start bit (low) for one bit time
// DATA  | data bit sh[idx] for one bit time, idx = 0..DATA_W-1
// STOP  | stop bit (high); last cycle may chain straight into START
module filt_sample_tx #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    filt_sample_tx_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0] sh, sh_nxt;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              push, pop, tmr_done;
    logic              tx_d, busy_d;
    logic              tx_q, busy_q, full_q, empty_q, ovf_q;

    // A pop in the same cycle never frees a slot for a write to a full FIFO.
    assign push     = bus.y_valid && (count != CNT_W'(FIFO_DEPTH));
    assign tmr_done = (tmr == TMR_W'(CLKS_PER_BIT - 1));

    // FSM state, bit timer, bit index and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tmr   <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            idx   <= idx_nxt;
            sh    <= sh_nxt;
        end
    end

    // Next-state logic; the timer restarts on every state or bit change
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr + 1'b1;
        idx_nxt   = idx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                tmr_nxt = '0;
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (tmr_done) begin
                    tmr_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tmr_done) begin
                    tmr_nxt = '0;
                    if (idx == IDX_W'(DATA_W - 1)) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tmr_done) begin
                    tmr_nxt = '0;
                    if (count != '0) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                tmr_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so tx/busy can be registered
    always_comb begin
        sh_nxt = pop ? mem[rd_ptr] : sh;
        tx_d   = 1'b1;
        busy_d = (state_nxt != IDLE);
        case (state_nxt)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_nxt[idx_nxt];
            default: tx_d = 1'b1;
        endcase
    end

    // FIFO occupancy after this edge
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // Sample storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.y_in;
        end
    end

    // FIFO pointers, status flags and registered line outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count_nxt;
            full_q  <= (count_nxt == CNT_W'(FIFO_DEPTH));
            empty_q <= (count_nxt == '0);
            if (bus.y_valid && !push) ovf_q <= 1'b1;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_empty = empty_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_filt_sample_tx.sv
// Bench for filt_sample_tx: frame-level reference model, UART receiver,
// directed scenarios plus a randomized burst phase.
module tb_filt_sample_tx;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;
    localparam int CPB2  = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    filt_sample_tx_if #(.DATA_W(DW)) bus4 ();
    filt_sample_tx_if #(.DATA_W(DW)) bus2 ();

    filt_sample_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4));
    filt_sample_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting samples and the remaining length of
    // the frame on the line. A new frame may start when the line is idle or on
    // the last cycle of the current frame.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_cur = '0;
    int            m_left = 0;
    bit            m_ovf = 1'b0;
    bit            m_wr_ok, m_pop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            exp_q.delete();
            m_left = 0;
            m_ovf  = 1'b0;
        end else begin
            m_wr_ok = bus4.y_valid && (mq.size() < DEPTH);
            m_pop   = (m_left <= 1) && (mq.size() > 0);
            if (bus4.y_valid && !m_wr_ok) m_ovf = 1'b1;
            if (m_pop) begin
                m_cur  = mq.pop_front();
                m_left = FRAME;
            end else if (m_left > 0) begin
                m_left--;
            end
            if (m_wr_ok) begin
                mq.push_back(bus4.y_in);
                exp_q.push_back(bus4.y_in);
            end
        end
    end

    function automatic logic m_tx();
        int slot;
        if (m_left == 0) return 1'b1;
        slot = (FRAME - m_left) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= DW) return m_cur[slot-1];
        return 1'b1;
    endfunction

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        check_val("tx",         bus4.tx,         m_tx());
        check_val("busy",       bus4.busy,       m_left > 0);
        check_val("fifo_full",  bus4.fifo_full,  mq.size() == DEPTH);
        check_val("fifo_empty", bus4.fifo_empty, mq.size() == 0);
        check_val("overflow",   bus4.overflow,   m_ovf);
    end

    // UART receiver on dut4: mid-bit sampling, checks bytes against accepted samples
    bit            rx_act = 1'b0;
    int            rx_t = 0;
    int            rx_n = 0;
    int            rx_b;
    logic [DW-1:0] rx_sh = '0;
    logic [DW-1:0] rx_exp;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (bus4.tx === 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
            if (rx_t >= CPB + CPB / 2 && ((rx_t - CPB / 2) % CPB) == 0) begin
                rx_b = (rx_t - CPB / 2) / CPB - 1;
                if (rx_b < DW) begin
                    rx_sh[rx_b] = bus4.tx;
                end else begin
                    check_val("rx_stop", bus4.tx, 1);
                    if (exp_q.size() > 0) begin
                        rx_exp = exp_q.pop_front();
                        check_val("rx_data", rx_sh, rx_exp);
                    end else begin
                        check_val("rx_unexpected_frame", exp_q.size(), 1);
                    end
                    rx_n++;
                    rx_act = 1'b0;
                end
            end
        end
    end

    // Busy run-length monitors; dut2 also records the line during a frame
    int   run4 = 0, last_run4 = 0;
    int   run2 = 0, last_run2 = 0;
    logic tx2_hist [64];

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            run4 = 0;
            run2 = 0;
        end else begin
            if (bus4.busy === 1'b1) run4++;
            else if (run4 > 0) begin last_run4 = run4; run4 = 0; end
            if (bus2.busy === 1'b1) begin
                if (run2 < 64) tx2_hist[run2] = bus2.tx;
                run2++;
            end else if (run2 > 0) begin
                last_run2 = run2;
                run2 = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bus4.y_in    = d;
        bus4.y_valid = 1'b1;
        step();
        bus4.y_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            if (bus4.busy === 1'b0 && bus4.fifo_empty === 1'b1) break;
            step();
        end
        if (i == max_cycles) check_val("idle_timeout", bus4.busy, 0);
        step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [9:0] pat_a5;
    int         nb, rx0;
    logic       exp_bit;

    initial begin
        bus4.y_in = '0; bus4.y_valid = 1'b0;
        bus2.y_in = '0; bus2.y_valid = 1'b0;
        #1 reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();

        // 1: idle outputs after reset, then reset in the middle of a frame
        check_val("rst_tx",    bus4.tx, 1);
        check_val("rst_busy",  bus4.busy, 0);
        check_val("rst_empty", bus4.fifo_empty, 1);
        check_val("rst_full",  bus4.fifo_full, 0);
        check_val("rst_ovf",   bus4.overflow, 0);
        send(8'h11); send(8'h22); send(8'h33);
        repeat (10) step();
        check_val("midframe_busy", bus4.busy, 1);
        reset = 1'b1;
        #1;
        check_val("midrst_tx",    bus4.tx, 1);
        check_val("midrst_busy",  bus4.busy, 0);
        check_val("midrst_empty", bus4.fifo_empty, 1);
        step();
        reset = 1'b0;
        nb = 0;
        repeat (100) begin step(); nb += int'(bus4.busy); end
        check_val("no_frame_after_rst", nb, 0);

        // 2: single 0xA5, latency and exact line pattern
        pat_a5 = 10'b11_0100_1010;
        send(8'hA5);
        check_val("lat_busy_k", bus4.busy, 0);
        check_val("lat_tx_k",   bus4.tx, 1);
        step();
        for (int c = 0; c < FRAME; c++) begin
            check_val("a5_line", bus4.tx, pat_a5[c / CPB]);
            step();
        end
        check_val("a5_busy_end", bus4.busy, 0);
        step();
        check_val("a5_frame_len", last_run4, FRAME);

        // 3: three back-to-back frames
        rx0 = rx_n;
        bus4.y_valid = 1'b1;
        bus4.y_in = 8'h00; step();
        bus4.y_in = 8'hFF; step();
        bus4.y_in = 8'h3C; step();
        bus4.y_valid = 1'b0;
        wait_idle(4 * FRAME);
        check_val("b2b_run_len", last_run4, 3 * FRAME);
        check_val("b2b_rx_count", rx_n - rx0, 3);

        // 5: 800-sample ramp, one sample per frame time
        rx0 = rx_n;
        for (int i = 0; i < 800; i++) begin
            send(8'(i % 256));
            repeat (FRAME - 1) step();
        end
        wait_idle(3 * FRAME);
        check_val("ramp_rx_count", rx_n - rx0, 800);
        check_val("ramp_ovf", bus4.overflow, 0);
        check_val("ramp_pending", exp_q.size(), 0);

        // random bursts, fast enough to fill the FIFO and drop samples
        for (int i = 0; i < 1500; i++) begin
            bus4.y_valid = ($urandom_range(0, 9) < 2);
            bus4.y_in    = 8'($urandom);
            step();
        end
        bus4.y_valid = 1'b0;
        wait_idle((DEPTH + 2) * FRAME);
        check_val("rand_pending", exp_q.size(), 0);

        // 4: fill to full, one dropped sample, 17 frames out
        pulse_reset();
        rx0 = rx_n;
        for (int i = 0; i < 18; i++) begin
            bus4.y_in    = 8'(i);
            bus4.y_valid = 1'b1;
            step();
            if (i == 15) check_val("full_after_16", bus4.fifo_full, 0);
            if (i == 16) check_val("full_after_17", bus4.fifo_full, 1);
            if (i == 16) check_val("ovf_after_17", bus4.overflow, 0);
        end
        bus4.y_valid = 1'b0;
        check_val("ovf_after_18", bus4.overflow, 1);
        wait_idle(20 * FRAME);
        check_val("fill_rx_count", rx_n - rx0, 17);
        check_val("ovf_sticky", bus4.overflow, 1);

        // 6: CLKS_PER_BIT=2, single 0x80
        bus2.y_in    = 8'h80;
        bus2.y_valid = 1'b1;
        step();
        bus2.y_valid = 1'b0;
        repeat (30) step();
        check_val("cpb2_frame_len", last_run2, 20);
        for (int c = 0; c < 20; c++) begin
            if (c / CPB2 == 0)       exp_bit = 1'b0;
            else if (c / CPB2 <= DW) exp_bit = (8'h80 >> (c / CPB2 - 1)) & 8'h01;
            else                     exp_bit = 1'b1;
            check_val("cpb2_line", tx2_hist[c], exp_bit);
        end
        check_val("cpb2_busy_end", bus2.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
